can_tx_sequencer: RTL and testbench
===================================

// Module: can_tx_sequencer
// PURPOSE
//  Round-robin arbiter and write sequencer that shares one Canakari CAN node between N_BUS
//  transmit requesters. Grants one bus at a time and latches its 76-bit message.
//  Drives the CAN register-interface write strobes for the fixed order ID -> D1-2 -> D3-4
//  -> D5-6 -> D7-8 -> TX control, then waits for the node's TX-done indication and acks
//  the requester. Sits between the per-bus message sources and the CAN register interface.
// PARAMETERS
//  N_BUS        32    number of requesters; 2..32, index carried on 5-bit select
//  TIMEOUT_CYC  4096  cycles allowed in WAIT_DONE before abort (CAN_TX_TIMEOUT_EN only)
//  TO_W         13    timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clock            in   1      system clock, rising edge
//  rst              in   1      asynchronous, active-low reset
//  tx_req           in   N_BUS  level request per bus; held until matching tx_ack/tx_err
//  tx_msg           in   76     message of bus grant_sel (external mux), valid in LATCH
//  tx_done_irq      in   1      Canakari TX-complete pulse/level, sampled in WAIT_DONE only
//  grant_sel        out  5      index of granted bus; steers external message mux
//  data_tra_select  out  5      bus index sent with the message to the CAN interface
//  data_tra_mes     out  76     latched message, stable from LATCH until next LATCH
//  can_addr         out  5      Canakari register address for current write
//  can_write        out  1      1-cycle write strobe, active high
//  busy             out  1      high in every state except IDLE
//  tx_ack           out  N_BUS  1-cycle one-hot pulse on successful completion
//  tx_err           out  N_BUS  1-cycle one-hot pulse on abort (timeout)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, rr_ptr=N_BUS-1, all outputs 0, data_tra_mes=0.
//  States: IDLE -> LATCH -> WR -> GAP -> (WR | WAIT_DONE) -> DONE -> IDLE.
//  IDLE: if |tx_req, pick the first set bit searching upward from rr_ptr+1 (mod N_BUS),
//    register it on grant_sel/data_tra_select, rr_ptr<=winner, go LATCH. Decision takes 1 cycle.
//  LATCH: data_tra_mes<=tx_msg; wr_idx<=0; go WR.
//  WR: can_write=1, can_addr=ADDR[wr_idx] with ADDR = {0x0C,0x0A,0x09,0x08,0x07,0x0D}; go GAP.
//  GAP: can_write=0, can_addr held; wr_idx==5 -> WAIT_DONE, else wr_idx+1 -> WR.
//    Sequence is 6 strobes, one every 2 cycles; first strobe 2 cycles after grant.
//  WAIT_DONE: tx_done_irq=1 -> DONE. tx_done_irq during LATCH/WR/GAP is ignored (not stored).
//  DONE: tx_ack[grant_sel]=1 for 1 cycle; return to IDLE. Next grant earliest 1 cycle later.
//  All outputs registered. can_addr=0 outside WR/GAP.
//  Fairness: a bus granted is lowest priority in the next arbitration. rr_ptr wraps
//    N_BUS-1 -> 0. Requests of bus indices >= N_BUS are ignored.
//  tx_req dropped mid-sequence: sequence completes, ack still pulsed (no cancel).
//  Requests arriving while busy wait; they are not lost (level-sensitive).
//  Simultaneous tx_done_irq and timeout expiry in the same cycle: done wins (ack, not err).
// CONFIGURATION
//  CAN_TX_TIMEOUT_EN defined: counter cleared on entry to WAIT_DONE, increments each
//    cycle; reaching TIMEOUT_CYC without tx_done_irq -> pulse tx_err[grant_sel] 1 cycle,
//    return to IDLE, rr_ptr still advanced.
//  Not defined: no counter, tx_err tied to 0, WAIT_DONE waits indefinitely.
// TESTING
//  1 Reset: rst=0 mid-WR -> all outputs 0 immediately; after release, busy=0, can_write=0.
//  2 Single: tx_req[3]=1, tx_msg=76'hA5..; done after 3 cycles -> grant_sel=3,
//    6 strobes addr 0C,0A,09,08,07,0D two cycles apart, data_tra_mes=tx_msg, tx_ack=0x8.
//  3 Round-robin: tx_req bits 0,5,31 held -> grants 0,5,31,0 in that order; no bus is
//    granted twice before the others are served.
//  4 Early irq: tx_done_irq pulsed during third WR -> ignored; ack only after a WAIT_DONE pulse.
//  5 Timeout (CAN_TX_TIMEOUT_EN, TIMEOUT_CYC=16): no irq -> tx_err[grant] after 16 cycles
//    in WAIT_DONE, tx_ack=0; irq on cycle 16 itself -> tx_ack, no err.
//  6 Drop request: tx_req[7] deasserted after grant -> full 6-write sequence, tx_ack[7] pulses.

Source files
------------

// File: rtl/can_tx_sequencer.sv
// can_tx_sequencer: round-robin share of one Canakari CAN node between N_BUS requesters.
// Optional WAIT_DONE timeout abort: define CAN_TX_TIMEOUT_EN.
module can_tx_sequencer #(
    parameter int N_BUS       = 32,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [N_BUS-1:0] tx_req,
    input  logic [75:0]      tx_msg,
    input  logic             tx_done_irq,
    output logic [4:0]       grant_sel,
    output logic [4:0]       data_tra_select,
    output logic [75:0]      data_tra_mes,
    output logic [4:0]       can_addr,
    output logic             can_write,
    output logic             busy,
    output logic [N_BUS-1:0] tx_ack,
    output logic [N_BUS-1:0] tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_WR,
        S_GAP,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       wr_idx_q;
    logic [2:0]       wr_idx_d;
    logic [4:0]       rr_ptr;
    logic [4:0]       cand;
    logic [4:0]       win_idx;
    logic             win_vld;
    logic             expire;
    logic [4:0]       can_addr_d;
    logic             can_write_d;
    logic             busy_d;
    logic [N_BUS-1:0] tx_ack_d;
    logic [N_BUS-1:0] gnt_1h;

    // Register write order: ID, D1-2, D3-4, D5-6, D7-8, TX control
    function automatic logic [4:0] addr_of(input logic [2:0] idx);
        case (idx)
            3'd0:    addr_of = 5'h0C;
            3'd1:    addr_of = 5'h0A;
            3'd2:    addr_of = 5'h09;
            3'd3:    addr_of = 5'h08;
            3'd4:    addr_of = 5'h07;
            default: addr_of = 5'h0D;
        endcase
    endfunction

    // Search upward from the bus after the last winner
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_BUS; i++) begin
            cand = 5'((int'(rr_ptr) + 1 + i) % N_BUS);
            if (!win_vld && tx_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign gnt_1h = {{(N_BUS-1){1'b0}}, 1'b1} << grant_sel;

`ifdef CAN_TX_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt;
    logic [N_BUS-1:0] tx_err_d;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state_q != S_WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign expire   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign tx_err_d = (state_d == S_ERR) ? gnt_1h : '0;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tx_err <= '0;
        end else begin
            tx_err <= tx_err_d;
        end
    end
`else
    logic [TO_W-1:0] unused_to;
    assign unused_to = TO_W'(TIMEOUT_CYC);
    assign expire    = 1'b0;
    assign tx_err    = '0;
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            wr_idx_q        <= '0;
            rr_ptr          <= 5'(N_BUS - 1);
            grant_sel       <= '0;
            data_tra_select <= '0;
            data_tra_mes    <= '0;
            can_addr        <= '0;
            can_write       <= 1'b0;
            busy            <= 1'b0;
            tx_ack          <= '0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            can_addr  <= can_addr_d;
            can_write <= can_write_d;
            busy      <= busy_d;
            tx_ack    <= tx_ack_d;
            if (state_q == S_IDLE && win_vld) begin
                rr_ptr          <= win_idx;
                grant_sel       <= win_idx;
                data_tra_select <= win_idx;
            end
            if (state_q == S_LATCH) begin
                data_tra_mes <= tx_msg;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d  = S_WR;
                wr_idx_d = '0;
            end
            S_WR: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (wr_idx_q == 3'd5) begin
                    state_d = S_WAIT;
                end else begin
                    state_d  = S_WR;
                    wr_idx_d = wr_idx_q + 3'd1;
                end
            end
            // done is checked first so it wins over a same-cycle expiry
            S_WAIT: begin
                if (tx_done_irq) state_d = S_DONE;
                else if (expire) state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        can_write_d = (state_d == S_WR);
        busy_d      = (state_d != S_IDLE);
        can_addr_d  = '0;
        if (state_d == S_WR || state_d == S_GAP) begin
            can_addr_d = addr_of(wr_idx_d);
        end
        tx_ack_d = (state_d == S_DONE) ? gnt_1h : '0;
    end

endmodule

// File: tb/tb_can_tx_sequencer.sv
// tb_can_tx_sequencer: randomized self-checking bench for can_tx_sequencer.
// Reference model tracks the round-robin pointer and the expected write timeline.
module tb_can_tx_sequencer;

    localparam int N      = 32;
    localparam int WSTART = 14;
    localparam int TO_CYC = 16;
`ifdef CAN_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst;
    logic [N-1:0]  tx_req;
    logic [75:0]   tx_msg;
    logic          tx_done_irq;
    logic [4:0]    grant_sel;
    logic [4:0]    data_tra_select;
    logic [75:0]   data_tra_mes;
    logic [4:0]    can_addr;
    logic          can_write;
    logic          busy;
    logic [N-1:0]  tx_ack;
    logic [N-1:0]  tx_err;

    logic [75:0]   msgs [N];
    logic [4:0]    exp_addr [6] = '{5'h0C, 5'h0A, 5'h09, 5'h08, 5'h07, 5'h0D};
    int            checks = 0;
    int            errors = 0;
    int            model_ptr = N - 1;

    always #5 clock = ~clock;

    // external message mux steered by the grant
    assign tx_msg = msgs[grant_sel];

    can_tx_sequencer #(
        .N_BUS      (N),
        .TIMEOUT_CYC(TO_CYC),
        .TO_W       (5)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .tx_req         (tx_req),
        .tx_msg         (tx_msg),
        .tx_done_irq    (tx_done_irq),
        .grant_sel      (grant_sel),
        .data_tra_select(data_tra_select),
        .data_tra_mes   (data_tra_mes),
        .can_addr       (can_addr),
        .can_write      (can_write),
        .busy           (busy),
        .tx_ack         (tx_ack),
        .tx_err         (tx_err)
    );

    function automatic int exp_winner(input logic [N-1:0] r);
        for (int j = 1; j <= N; j++) begin
            if (r[(model_ptr + j) % N]) return (model_ptr + j) % N;
        end
        return -1;
    endfunction

    // One grant-to-idle transaction; starts at a negedge with the DUT idle.
    task automatic txn(input logic [N-1:0] req, input int irq_at,
                       input int early_at, input bit drop);
        int         w, c, n_stray, n_ack, n_err, ack_c, err_c, end_c;
        logic [N-1:0] ack_v, err_v, exp_1h;
        logic       exp_wr;
        logic [4:0] exp_a;
        bit         exp_err;
        w = exp_winner(req);
        exp_1h = '0;
        exp_1h[w] = 1'b1;
        exp_err = TO_EN && (irq_at < WSTART || irq_at >= WSTART + TO_CYC);
        end_c = exp_err ? WSTART + TO_CYC : irq_at + 1;
        n_stray = 0; n_ack = 0; n_err = 0; ack_c = -1; err_c = -1;
        ack_v = '0; err_v = '0;
        tx_req = req;
        c = 0;
        while (c < 300) begin
            @(negedge clock);
            c++;
            if (c == 1) begin
                checks++;
                if (grant_sel !== 5'(w) || data_tra_select !== 5'(w) ||
                    busy !== 1'b1 || can_write !== 1'b0) begin
                    errors++;
                    $display("FAIL grant: grant_sel=%0d select=%0d busy=%b wr=%b expected %0d/%0d/1/0",
                             grant_sel, data_tra_select, busy, can_write, w, w);
                end
                if (drop) tx_req[w] = 1'b0;
            end
            if (c == 2) begin
                checks++;
                if (data_tra_mes !== msgs[w]) begin
                    errors++;
                    $display("FAIL latch: data_tra_mes=%h expected %h", data_tra_mes, msgs[w]);
                end
            end
            if (c >= 2 && c <= 13) begin
                exp_wr = (c % 2 == 0);
                exp_a  = exp_addr[(c - 2) / 2];
                checks++;
                if (can_write !== exp_wr || can_addr !== exp_a) begin
                    errors++;
                    $display("FAIL strobe c%0d: can_write=%b can_addr=%h expected %b/%h",
                             c, can_write, can_addr, exp_wr, exp_a);
                end
            end
            if (c > 13 && can_write !== 1'b0) n_stray++;
            if (tx_ack !== '0) begin n_ack++; ack_v = tx_ack; ack_c = c; end
            if (tx_err !== '0) begin n_err++; err_v = tx_err; err_c = c; end
            if (c > 1 && busy === 1'b0) break;
            tx_done_irq = (c == irq_at || c == early_at);
        end
        tx_done_irq = 1'b0;
        tx_req = '0;
        checks++;
        if (c >= 300) begin
            errors++;
            $display("FAIL timeout: still busy after %0d cycles", c);
        end
        checks++;
        if (c != end_c + 1 || n_stray != 0) begin
            errors++;
            $display("FAIL idle: back to idle at cycle %0d stray=%0d expected cycle %0d stray=0",
                     c, n_stray, end_c + 1);
        end
        checks++;
        if (exp_err) begin
            if (n_err != 1 || err_v !== exp_1h || err_c != end_c || n_ack != 0) begin
                errors++;
                $display("FAIL err: tx_err=%h n=%0d c=%0d acks=%0d expected %h n=1 c=%0d acks=0",
                         err_v, n_err, err_c, n_ack, exp_1h, end_c);
            end
        end else begin
            if (n_ack != 1 || ack_v !== exp_1h || ack_c != end_c || n_err != 0) begin
                errors++;
                $display("FAIL ack: tx_ack=%h n=%0d c=%0d errs=%0d expected %h n=1 c=%0d errs=0",
                         ack_v, n_ack, ack_c, n_err, exp_1h, end_c);
            end
        end
        model_ptr = w;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_req = '0;
        tx_done_irq = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || can_write !== 1'b0 || grant_sel !== 5'd0 ||
            data_tra_mes !== 76'd0 || tx_ack !== '0 || tx_err !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b wr=%b grant=%0d mes=%h ack=%h err=%h expected zeros",
                     busy, can_write, grant_sel, data_tra_mes, tx_ack, tx_err);
        end
        rst = 1'b1;
        @(negedge clock);
        msgs[3] = 76'hA5A5A5A5A5A5A5A5A5A;
        tx_req = N'(1) << 3;
        repeat (2) @(negedge clock);
        checks++;
        if (can_write !== 1'b1 || data_tra_mes !== msgs[3]) begin
            errors++;
            $display("FAIL pre_reset: can_write=%b mes=%h expected 1/%h", can_write, data_tra_mes, msgs[3]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || can_write !== 1'b0 || can_addr !== 5'd0 || grant_sel !== 5'd0 ||
            data_tra_select !== 5'd0 || data_tra_mes !== 76'd0 || tx_ack !== '0 || tx_err !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b wr=%b addr=%h grant=%0d sel=%0d mes=%h expected zeros",
                     busy, can_write, can_addr, grant_sel, data_tra_select, data_tra_mes);
        end
        tx_req = '0;
        @(negedge clock);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || can_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: busy=%b can_write=%b expected 0/0", busy, can_write);
        end
        model_ptr = N - 1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] r;
        r = '0;
        r[0] = 1'b1; r[5] = 1'b1; r[31] = 1'b1;
        for (int k = 0; k < 4; k++) txn(r, WSTART + k, -1, 1'b0);
    endtask

    task automatic test_single();
        msgs[3] = 76'hA5A5A5A5A5A5A5A5A5A;
        txn(N'(1) << 3, WSTART + 3, -1, 1'b0);
    endtask

    task automatic test_early_irq();
        txn(N'(1) << 12 | N'(1) << 20, WSTART + 6, 6, 1'b0);
    endtask

    task automatic test_drop_request();
        txn(N'(1) << 7, WSTART + 1, -1, 1'b1);
    endtask

`ifdef CAN_TX_TIMEOUT_EN
    task automatic test_timeout();
        txn(N'(1) << 9, -1, -1, 1'b0);
        txn(N'(1) << 9, WSTART + TO_CYC - 1, -1, 1'b0);
        txn(N'(1) << 2 | N'(1) << 9, WSTART + TO_CYC, -1, 1'b0);
    endtask
`else
    task automatic test_no_timeout();
        txn(N'(1) << 9, WSTART + 40, -1, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] r;
        int           early;
        for (int k = 0; k < 20; k++) begin
            r = N'($urandom);
            if (r == '0) r[k] = 1'b1;
            early = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 13)) : -1;
            txn(r, WSTART + int'($urandom_range(0, 5)), early, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) msgs[i] = 76'({$urandom, $urandom, $urandom});
        test_reset();
        test_round_robin();
        test_single();
        test_early_irq();
        test_drop_request();
`ifdef CAN_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
